// File: rtl/multi_flux_fifo.sv
// multi_flux_fifo: FLUX independent circular queues sharing one push port.
// The tag in the MSBs of a pushed word picks the target queue. The read
// side has one pop request per queue and a single first-word-fall-through
// output word of the form {flux index, payload}. Overflow and underflow
// events latch into sticky error flags that only reset clears.

module multi_flux_fifo #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_din,
  output logic [FLUX-1:0]  o_full,
  input  logic [FLUX-1:0]  i_read,
  output logic [FLUX-1:0]  o_empty,
  output logic [WIDTH-1:0] o_dout,
  output logic [1:0]       o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem   [FLUX][DEPTH];
  logic [PTR_W-1:0]      r_rptr  [FLUX];
  logic [PTR_W-1:0]      r_wptr  [FLUX];
  logic [CNT_W-1:0]      r_count [FLUX];
  logic [1:0]            r_err;

  logic [TAG_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [FLUX-1:0]       w_pushEn;
  logic [FLUX-1:0]       w_popEn;
  logic                  w_popValid;
  logic [TAG_WIDTH-1:0]  w_popIdx;
  logic                  w_multiRead;
  logic                  w_pushDrop;
  logic                  w_popErr;

  assign w_tag       = i_din[WIDTH-1 -: TAG_WIDTH];
  assign w_payload   = i_din[DATA_WIDTH-1:0];
  assign w_multiRead = |(i_read & (i_read - FLUX'(1)));
  assign o_err       = r_err;

  // Full/empty flags come only from the registered occupancy counts.
  always_comb begin
    o_full  = '0;
    o_empty = '0;
    for (int f = 0; f < FLUX; f++) begin
      o_full[f]  = (r_count[f] == CNT_W'(DEPTH));
      o_empty[f] = (r_count[f] == '0);
    end
  end

  // Pick the lowest requested flux; scanning downward lets the lowest win.
  always_comb begin
    w_popValid = 1'b0;
    w_popIdx   = '0;
    for (int f = FLUX - 1; f >= 0; f--) begin
      if (i_read[f]) begin
        w_popValid = 1'b1;
        w_popIdx   = TAG_WIDTH'(f);
      end
    end
  end

  // Per-flux accept decisions; a push to a full or nonexistent flux and a pop
  // from an empty flux are refused and reported as errors.
  always_comb begin
    w_pushEn = '0;
    w_popEn  = '0;
    for (int f = 0; f < FLUX; f++) begin
      w_pushEn[f] = i_write && (w_tag == TAG_WIDTH'(f)) && !o_full[f];
      w_popEn[f]  = w_popValid && (w_popIdx == TAG_WIDTH'(f)) && !o_empty[f];
    end
    w_pushDrop = i_write && !(|w_pushEn);
    w_popErr   = w_multiRead || (w_popValid && !(|w_popEn));
  end

  // Show-ahead head word: requested flux first, else lowest non-empty flux.
  // A requested but empty flux shows zero so stale storage never leaks out.
  always_comb begin
    o_dout = '0;
    if (w_popValid) begin
      if (!o_empty[w_popIdx]) begin
        o_dout = {w_popIdx, r_mem[w_popIdx][r_rptr[w_popIdx]]};
      end
    end else begin
      for (int f = FLUX - 1; f >= 0; f--) begin
        if (!o_empty[f]) begin
          o_dout = {TAG_WIDTH'(f), r_mem[f][r_rptr[f]]};
        end
      end
    end
  end

  // Storage array is left unreset; only accepted pushes write it.
  always_ff @(posedge i_clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (w_pushEn[f]) begin
        r_mem[f][r_wptr[f]] <= w_payload;
      end
    end
  end

  // Pointers, counts and sticky errors, with reset overriding all traffic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int f = 0; f < FLUX; f++) begin
        r_rptr[f]  <= '0;
        r_wptr[f]  <= '0;
        r_count[f] <= '0;
      end
      r_err <= 2'b00;
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (w_pushEn[f]) begin
          r_wptr[f] <= r_wptr[f] + PTR_W'(1);
        end
        if (w_popEn[f]) begin
          r_rptr[f] <= r_rptr[f] + PTR_W'(1);
        end
        r_count[f] <= r_count[f] + CNT_W'(w_pushEn[f]) - CNT_W'(w_popEn[f]);
      end
      if (w_pushDrop) begin
        r_err[0] <= 1'b1;
      end
      if (w_popErr) begin
        r_err[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_flux_fifo.sv
// Testbench for multi_flux_fifo (FLUX=2, DATA_WIDTH=8, DEPTH=4).
// A queue-based reference model tracks each flux; a compare process checks
// flags, head word and error bits every cycle, and directed scenarios pin
// hand-computed literal values. A randomized phase follows.

module tb_multi_flux_fifo;

  localparam int FLUX  = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int WIDTH = 9;

  logic             clk;
  logic             rst;
  logic             write;
  logic [WIDTH-1:0] din;
  logic [FLUX-1:0]  full;
  logic [FLUX-1:0]  read;
  logic [FLUX-1:0]  empty;
  logic [WIDTH-1:0] dout;
  logic [1:0]       err;

  int nVectors     = 0;
  int nMiscompares = 0;
  bit checkEn      = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [1:0]    mErr;

  int  popF;
  int  pushF;
  bit  doPop;
  bit  doPush;

  multi_flux_fifo #(.FLUX(FLUX), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_write (write),
    .i_din   (din),
    .o_full  (full),
    .i_read  (read),
    .o_empty (empty),
    .o_dout  (dout),
    .o_err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int qSize(input int f);
    return (f == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DW-1:0] qFront(input int f);
    return (f == 0) ? q0[0] : q1[0];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit w, input logic [WIDTH-1:0] d, input logic [1:0] r, input bit rs);
    @(posedge clk);
    #1;
    write = w;
    din   = d;
    read  = r;
    rst   = rs;
  endtask

  // Reference model: each flux is a bounded queue; decisions use pre-edge occupancy.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      mErr = 2'b00;
    end else begin
      popF   = read[0] ? 0 : (read[1] ? 1 : -1);
      doPop  = (popF >= 0) && (qSize(popF) > 0);
      pushF  = int'(din[WIDTH-1]);
      doPush = write && (qSize(pushF) < DEPTH);
      if (write && !doPush) mErr[0] = 1'b1;
      if ((read != 2'b00) && (!doPop || read == 2'b11)) mErr[1] = 1'b1;
      if (doPop) begin
        if (popF == 0) void'(q0.pop_front());
        else           void'(q1.pop_front());
      end
      if (doPush) begin
        if (pushF == 0) q0.push_back(din[DW-1:0]);
        else            q1.push_back(din[DW-1:0]);
      end
    end
  end

  // Every cycle compare DUT outputs with what the model says they must be.
  always @(negedge clk) begin
    if (checkEn) begin
      logic [1:0]       expFull;
      logic [1:0]       expEmpty;
      logic [WIDTH-1:0] expDout;
      bit               doutKnown;
      int               f;
      expFull  = {qSize(1) == DEPTH, qSize(0) == DEPTH};
      expEmpty = {qSize(1) == 0, qSize(0) == 0};
      doutKnown = 1'b1;
      expDout   = '0;
      if (read != 2'b00) begin
        f = read[0] ? 0 : 1;
        if (qSize(f) > 0) expDout = {f[0], qFront(f)};
        else doutKnown = 1'b0;
      end else if (qSize(0) > 0) begin
        expDout = {1'b0, qFront(0)};
      end else if (qSize(1) > 0) begin
        expDout = {1'b1, qFront(1)};
      end
      checkOutput("full", 16'(full), 16'(expFull));
      checkOutput("empty", 16'(empty), 16'(expEmpty));
      checkOutput("err", 16'(err), 16'(mErr));
      if (doutKnown) checkOutput("dout", 16'(dout), 16'(expDout));
    end
  end

  initial begin
    rst   = 1'b1;
    write = 1'b0;
    din   = '0;
    read  = '0;

    // Power-up reset
    applyStimulus(0, 9'h000, 2'b00, 1);
    applyStimulus(0, 9'h000, 2'b00, 1);
    checkEn = 1'b1;
    #2;
    checkOutput("rst_empty", 16'(empty), 16'h0003);
    checkOutput("rst_full", 16'(full), 16'h0000);
    checkOutput("rst_dout", 16'(dout), 16'h0000);
    checkOutput("rst_err", 16'(err), 16'h0000);

    // Two words into flux 1, then pop both
    applyStimulus(1, 9'h111, 2'b00, 0);
    applyStimulus(1, 9'h122, 2'b00, 0);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s1_dout_idle", 16'(dout), 16'h0111);
    checkOutput("s1_empty", 16'(empty), 16'h0001);
    applyStimulus(0, 9'h000, 2'b10, 0);
    #2;
    checkOutput("s1_pop1", 16'(dout), 16'h0111);
    applyStimulus(0, 9'h000, 2'b10, 0);
    #2;
    checkOutput("s1_pop2", 16'(dout), 16'h0122);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s1_empty_end", 16'(empty), 16'h0003);

    // Fill flux 0, overflow, drain
    for (int i = 0; i < 4; i++) applyStimulus(1, 9'(8'h01 + i), 2'b00, 0);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s2_full", 16'(full), 16'h0001);
    applyStimulus(1, 9'h055, 2'b00, 0);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s2_err", 16'(err), 16'h0001);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 9'h000, 2'b01, 0);
      #2;
      checkOutput("s2_order", 16'(dout), 16'(9'h001 + i));
    end
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s2_empty", 16'(empty), 16'h0003);

    // Steady push+pop on flux 0 with 3 resident words, across two wraps
    for (int i = 0; i < 3; i++) applyStimulus(1, 9'(8'h31 + i), 2'b00, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 9'(8'h40 + i), 2'b01, 0);
      #2;
      checkOutput("s3_wrap", 16'(dout), (i < 3) ? 16'(16'h31 + i) : 16'(16'h40 + i - 3));
    end
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s3_empty", 16'(empty), 16'h0002);
    checkOutput("s3_head", 16'(dout), 16'h0045);
    for (int i = 0; i < 3; i++) applyStimulus(0, 9'h000, 2'b01, 0);

    // Cross-flux independence: flux 0 full, flux 1 empty
    for (int i = 0; i < 4; i++) applyStimulus(1, 9'(8'h61 + i), 2'b00, 0);
    applyStimulus(1, 9'h1A5, 2'b01, 0);
    #2;
    checkOutput("s4_pop_head", 16'(dout), 16'h0061);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s4_head", 16'(dout), 16'h0062);
    checkOutput("s4_empty", 16'(empty), 16'h0000);
    checkOutput("s4_full", 16'(full), 16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 9'h000, 2'b01, 0);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s4_flux1", 16'(dout), 16'h01A5);
    applyStimulus(0, 9'h000, 2'b10, 0);

    // Underflow and multi-bit read
    applyStimulus(0, 9'h000, 2'b00, 1);
    applyStimulus(0, 9'h000, 2'b01, 0);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s5_err", 16'(err), 16'h0002);
    checkOutput("s5_empty", 16'(empty), 16'h0003);
    applyStimulus(1, 9'h071, 2'b00, 0);
    applyStimulus(1, 9'h181, 2'b00, 0);
    applyStimulus(0, 9'h000, 2'b11, 0);
    #2;
    checkOutput("s5_multi_dout", 16'(dout), 16'h0071);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s5_multi_empty", 16'(empty), 16'h0001);
    checkOutput("s5_multi_head", 16'(dout), 16'h0181);

    // Mid-operation reset
    applyStimulus(1, 9'h0A1, 2'b00, 0);
    applyStimulus(1, 9'h0A2, 2'b00, 0);
    applyStimulus(1, 9'h1B1, 2'b00, 0);
    applyStimulus(1, 9'h1B2, 2'b00, 0);
    applyStimulus(0, 9'h000, 2'b00, 1);
    applyStimulus(0, 9'h000, 2'b00, 0);
    #2;
    checkOutput("s6_empty", 16'(empty), 16'h0003);
    checkOutput("s6_full", 16'(full), 16'h0000);
    checkOutput("s6_err", 16'(err), 16'h0000);
    checkOutput("s6_dout", 16'(dout), 16'h0000);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [1:0] rd;
      r = int'($urandom_range(0, 9));
      rd = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      applyStimulus($urandom_range(0, 9) < 6, 9'($urandom), rd, $urandom_range(0, 99) == 0);
    end
    applyStimulus(0, 9'h000, 2'b00, 0);
    @(posedge clk);
    #6;
    checkEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
